// File: rtl/fft.sv
// ---------------------------------------------------------------------------
// fft
//
// Streaming 4-point radix-4 DFT on complex fixed-point samples. One sample
// enters per clock and one frequency bin leaves per clock. The input is cut
// into back-to-back 4-sample frames, aligned to reset release. While one
// frame is being captured, the four bins of the previous frame are shifted
// out.
//
// Output scaling is 1/4 (arithmetic shift right by two, floor rounding), so
// the result always fits back into DW bits. Twiddles are only +-1 and +-j,
// so the datapath is adders only.
//
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset; discards any partial frame
//   data_in  : complex sample, [2*DW-1:DW] real, [DW-1:0] imag, signed
//   data_out : complex bin, same packing, registered
// ---------------------------------------------------------------------------
module fft #(
    parameter int DW = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2*DW-1:0] data_in,
    output logic [2*DW-1:0] data_out
);

    // Two guard bits are enough for an exact sum of four DW-bit terms.
    localparam int SW = DW + 2;

    typedef logic signed [SW-1:0] sum_t;

    logic [1:0]      r_cnt;
    logic [DW-1:0]   r_re [3];
    logic [DW-1:0]   r_im [3];
    logic [2*DW-1:0] r_hold1;
    logic [2*DW-1:0] r_hold2;
    logic [2*DW-1:0] r_hold3;

    sum_t w_r0, w_r1, w_r2, w_r3;
    sum_t w_i0, w_i1, w_i2, w_i3;
    sum_t w_x0r, w_x0i, w_x1r, w_x1i, w_x2r, w_x2i, w_x3r, w_x3i;

    logic [2*DW-1:0] w_bin0;
    logic [2*DW-1:0] w_bin1;
    logic [2*DW-1:0] w_bin2;
    logic [2*DW-1:0] w_bin3;
    logic            w_unused;

    // x0..x2 come from the buffer; x3 is taken straight from the input on
    // the cnt=3 edge so the bins are ready without an extra cycle.
    assign w_r0 = {{2{r_re[0][DW-1]}}, r_re[0]};
    assign w_i0 = {{2{r_im[0][DW-1]}}, r_im[0]};
    assign w_r1 = {{2{r_re[1][DW-1]}}, r_re[1]};
    assign w_i1 = {{2{r_im[1][DW-1]}}, r_im[1]};
    assign w_r2 = {{2{r_re[2][DW-1]}}, r_re[2]};
    assign w_i2 = {{2{r_im[2][DW-1]}}, r_im[2]};
    assign w_r3 = {{2{data_in[2*DW-1]}}, data_in[2*DW-1:DW]};
    assign w_i3 = {{2{data_in[DW-1]}}, data_in[DW-1:0]};

    // Multiplying by -j swaps real/imag with a sign change, hence the
    // crossed terms in X1 and X3.
    assign w_x0r = w_r0 + w_r1 + w_r2 + w_r3;
    assign w_x0i = w_i0 + w_i1 + w_i2 + w_i3;
    assign w_x1r = w_r0 + w_i1 - w_r2 - w_i3;
    assign w_x1i = w_i0 - w_r1 - w_i2 + w_r3;
    assign w_x2r = w_r0 - w_r1 + w_r2 - w_r3;
    assign w_x2i = w_i0 - w_i1 + w_i2 - w_i3;
    assign w_x3r = w_r0 - w_i1 - w_r2 + w_i3;
    assign w_x3i = w_i0 + w_r1 - w_i2 - w_r3;

    // Taking bits [DW+1:2] is the floor shift by two, truncated to DW bits.
    assign w_bin0 = {w_x0r[DW+1:2], w_x0i[DW+1:2]};
    assign w_bin1 = {w_x1r[DW+1:2], w_x1i[DW+1:2]};
    assign w_bin2 = {w_x2r[DW+1:2], w_x2i[DW+1:2]};
    assign w_bin3 = {w_x3r[DW+1:2], w_x3i[DW+1:2]};

    // The two fraction bits dropped by the scaling are intentionally unused.
    assign w_unused = ^{w_x0r[1:0], w_x0i[1:0], w_x1r[1:0], w_x1i[1:0],
                        w_x2r[1:0], w_x2i[1:0], w_x3r[1:0], w_x3i[1:0]};

    // Holding registers are only read at cnt=0..2 and only loaded at cnt=3,
    // so the previous frame's bins are never overwritten before they leave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 2'd0;
            r_re[0]  <= '0;
            r_re[1]  <= '0;
            r_re[2]  <= '0;
            r_im[0]  <= '0;
            r_im[1]  <= '0;
            r_im[2]  <= '0;
            r_hold1  <= '0;
            r_hold2  <= '0;
            r_hold3  <= '0;
            data_out <= '0;
        end else begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
                2'd0: begin
                    r_re[0]  <= data_in[2*DW-1:DW];
                    r_im[0]  <= data_in[DW-1:0];
                    data_out <= r_hold1;
                end
                2'd1: begin
                    r_re[1]  <= data_in[2*DW-1:DW];
                    r_im[1]  <= data_in[DW-1:0];
                    data_out <= r_hold2;
                end
                2'd2: begin
                    r_re[2]  <= data_in[2*DW-1:DW];
                    r_im[2]  <= data_in[DW-1:0];
                    data_out <= r_hold3;
                end
                default: begin
                    data_out <= w_bin0;
                    r_hold1  <= w_bin1;
                    r_hold2  <= w_bin2;
                    r_hold3  <= w_bin3;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft.sv
// ---------------------------------------------------------------------------
// tb_fft
//
// Directed bench for the streaming 4-point DFT. Each step drives one sample
// just after a rising edge, waits for the next rising edge and then checks
// data_out against a hand-computed value. The bins of a frame leave during
// the capture of the following frame, so each step's expected value is the
// bin scheduled for that edge.
//
// Packing reminders (DW = 17): value = (re mod 2^17) << 17 | (im mod 2^17)
//   (4,0)            = 34'h000080000
//   (1,0)            = 34'h000020000
//   (-1,0)           = 34'h3FFFE0000
//   (0,-1)           = 34'h00001FFFF
//   (0,1)            = 34'h000000001
//   (-65536,-65536)  = 34'h200010000
// ---------------------------------------------------------------------------
module tb_fft;

    localparam int DW = 17;

    localparam logic [2*DW-1:0] C_CONST = 34'h012345678;
    localparam logic [2*DW-1:0] C_P4    = 34'h000080000;
    localparam logic [2*DW-1:0] C_P1    = 34'h000020000;
    localparam logic [2*DW-1:0] C_M1    = 34'h3FFFE0000;
    localparam logic [2*DW-1:0] C_JM1   = 34'h00001FFFF;
    localparam logic [2*DW-1:0] C_JP1   = 34'h000000001;
    localparam logic [2*DW-1:0] C_MIN   = 34'h200010000;
    localparam logic [2*DW-1:0] C_ZERO  = 34'h000000000;

    logic            clk;
    logic            rst_n;
    logic [2*DW-1:0] data_in;
    logic [2*DW-1:0] data_out;

    int total = 0;
    int bad   = 0;

    fft #(.DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [2*DW-1:0] expected);
        total++;
        assert (data_out === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: data_out=%h expected=%h", tag, data_out, expected);
        end
    endtask

    // Drive one sample, let the next rising edge take it, then check.
    task automatic applyStimulus(input logic [2*DW-1:0] sample,
                                 input logic [2*DW-1:0] expected,
                                 input string tag);
        data_in = sample;
        @(posedge clk);
        #1;
        checkOutput(tag, expected);
    endtask

    initial begin
        rst_n   = 1'b0;
        data_in = 34'h12345678;
        #10;
        checkOutput("reset_hold", C_ZERO);
        #10;
        rst_n = 1'b1;

        // Frame 0: constant input; nothing valid until its cnt=3 edge.
        applyStimulus(C_CONST, C_ZERO,  "f0_pre0");
        applyStimulus(C_CONST, C_ZERO,  "f0_pre1");
        applyStimulus(C_CONST, C_ZERO,  "f0_pre2");
        applyStimulus(C_CONST, C_CONST, "f0_X0");

        // Frame 1: constant again; frame 0 X1..X3 are zero.
        applyStimulus(C_CONST, C_ZERO,  "f0_X1");
        applyStimulus(C_CONST, C_ZERO,  "f0_X2");
        applyStimulus(C_CONST, C_ZERO,  "f0_X3");
        applyStimulus(C_CONST, C_CONST, "f1_X0");

        // Frame 2: impulse at x0 -> every bin is (1,0).
        applyStimulus(C_P4,   C_ZERO, "f1_X1");
        applyStimulus(C_ZERO, C_ZERO, "f1_X2");
        applyStimulus(C_ZERO, C_ZERO, "f1_X3");
        applyStimulus(C_ZERO, C_P1,   "imp_X0");

        // Frame 3: impulse at x1 -> (1,0), (0,-1), (-1,0), (0,1).
        applyStimulus(C_ZERO, C_P1,   "imp_X1");
        applyStimulus(C_P4,   C_P1,   "imp_X2");
        applyStimulus(C_ZERO, C_P1,   "imp_X3");
        applyStimulus(C_ZERO, C_P1,   "sh_X0");

        // Frame 4: x0=(1,0) alone -> floor(1/4) = 0 in every bin.
        applyStimulus(C_P1,   C_JM1,  "sh_X1");
        applyStimulus(C_ZERO, C_M1,   "sh_X2");
        applyStimulus(C_ZERO, C_JP1,  "sh_X3");
        applyStimulus(C_ZERO, C_ZERO, "p1_X0");

        // Frame 5: most negative value everywhere -> X0 = (-65536,-65536).
        applyStimulus(C_MIN, C_ZERO, "p1_X1");
        applyStimulus(C_MIN, C_ZERO, "p1_X2");
        applyStimulus(C_MIN, C_ZERO, "p1_X3");
        applyStimulus(C_MIN, C_MIN,  "min_X0");

        // Frame 6: x0=(-1,0) alone -> floor(-1/4) = -1 in every bin.
        applyStimulus(C_M1,   C_ZERO, "min_X1");
        applyStimulus(C_ZERO, C_ZERO, "min_X2");
        applyStimulus(C_ZERO, C_ZERO, "min_X3");
        applyStimulus(C_ZERO, C_M1,   "m1_X0");

        // Frame 7 is cut short after x1; its X3 slot from frame 6 is pending.
        applyStimulus(C_CONST, C_M1, "m1_X1");
        applyStimulus(C_CONST, C_M1, "m1_X2");

        rst_n = 1'b0;
        #1;
        checkOutput("midreset_now", C_ZERO);
        #4;
        rst_n = 1'b1;

        // Frame 8 starts fresh at x0: the stale (-1,0) bin must not appear.
        applyStimulus(C_P4,   C_ZERO, "rr_pre0");
        applyStimulus(C_ZERO, C_ZERO, "rr_pre1");
        applyStimulus(C_ZERO, C_ZERO, "rr_pre2");
        applyStimulus(C_ZERO, C_P1,   "rr_X0");

        // Frame 9 flushes frame 8's remaining bins.
        applyStimulus(C_ZERO, C_P1,   "rr_X1");
        applyStimulus(C_ZERO, C_P1,   "rr_X2");
        applyStimulus(C_ZERO, C_P1,   "rr_X3");
        applyStimulus(C_ZERO, C_ZERO, "z_X0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
